ysyx_23060236_scoreboard: RTL

//  Issue-side scheduler between IDU and EXU. Tracks in-flight destination registers per GPR to block RAW

---
 rtl/ysyx_23060236_scoreboard_pkg.sv | 12 +
 rtl/ysyx_23060236_scoreboard_counter.sv | 32 +++
 rtl/ysyx_23060236_scoreboard.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060236_scoreboard_pkg.sv
// Shared constants and FSM encoding for the issue-side scoreboard.
package ysyx_23060236_scoreboard_pkg;
  localparam int SB_NR_REG = 16;
  localparam int SB_CNT_W  = 2;
  localparam int SB_OUT_W  = 3;

  typedef enum logic [1:0] {
    SB_IDLE   = 2'd0,
    SB_DRAIN  = 2'd1,
    SB_SERIAL = 2'd2
  } sb_state_e;
endpackage

// File: rtl/ysyx_23060236_scoreboard_counter.sv
// Saturating up/down counter; inc and dec in the same cycle cancel.
// err flags a decrement attempted while the counter is already empty.
module ysyx_23060236_sb_counter #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         at_max,
  output logic         err
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !at_max)
      cnt_d = cnt_q + W'(1);
    else if (dec && !inc && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == '1);
  assign err    = dec && (cnt_q == '0);
endmodule

// File: rtl/ysyx_23060236_scoreboard.sv
// Issue-side scheduler: per-GPR pending-write tracking for RAW hazards, same-cycle
// writeback forwarding, outstanding count, and drain/serialise handling for fence.i/ecall/mret.
module ysyx_23060236_scoreboard
  import ysyx_23060236_scoreboard_pkg::*;
#(
  parameter int NR_REG = SB_NR_REG,
  parameter int CNT_W  = SB_CNT_W,
  parameter int OUT_W  = SB_OUT_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [$clog2(NR_REG)-1:0] issue_rs1,
  input  logic [$clog2(NR_REG)-1:0] issue_rs2,
  input  logic                      issue_need_rs1,
  input  logic                      issue_need_rs2,
  input  logic [$clog2(NR_REG)-1:0] issue_rd,
  input  logic                      issue_reg_wen,
  input  logic                      issue_serial,
  input  logic                      flush,
  input  logic                      wb_valid,
  input  logic [$clog2(NR_REG)-1:0] wb_rd,
  input  logic                      wb_wen,
  input  logic                      retire_valid,
  output logic                      fwd_rs1,
  output logic                      fwd_rs2,
  output logic [NR_REG-1:0]         busy_mask,
  output logic                      drained,
  output logic                      raw_stall,
  output logic                      sb_err
);
  localparam int RW = $clog2(NR_REG);

  sb_state_e        state_q;
  logic [CNT_W-1:0] cnt [NR_REG];
  logic [NR_REG-1:0] at_max, err_r;
  logic [OUT_W-1:0] out_cnt;
  logic             out_max, out_err;
  logic             fire, wdec, hazard_rs1, hazard_rs2, sat, ofull, state_ok;
  logic             sb_err_q;

  assign wdec = wb_valid && wb_wen && (wb_rd != '0);

  // A single pending write retiring this very cycle is forwarded rather than stalled on.
  assign fwd_rs1 = issue_need_rs1 && (issue_rs1 != '0) && (cnt[issue_rs1] == CNT_W'(1))
                   && wdec && (wb_rd == issue_rs1);
  assign fwd_rs2 = issue_need_rs2 && (issue_rs2 != '0) && (cnt[issue_rs2] == CNT_W'(1))
                   && wdec && (wb_rd == issue_rs2);
  assign hazard_rs1 = issue_need_rs1 && (issue_rs1 != '0) && (cnt[issue_rs1] != '0) && !fwd_rs1;
  assign hazard_rs2 = issue_need_rs2 && (issue_rs2 != '0) && (cnt[issue_rs2] != '0) && !fwd_rs2;

  assign sat   = issue_reg_wen && (issue_rd != '0) && at_max[issue_rd]
                 && !(wdec && (wb_rd == issue_rd));
  assign ofull = out_max && !retire_valid;

  always_comb begin
    state_ok = 1'b0;
    case (state_q)
      SB_IDLE:   state_ok = !issue_serial || drained;
      SB_DRAIN:  state_ok = drained;
      default:   state_ok = 1'b0;
    endcase
  end

  assign issue_ready = !hazard_rs1 && !hazard_rs2 && !sat && !ofull && state_ok;
  assign fire        = issue_valid && issue_ready && !flush;
  assign raw_stall   = issue_valid && (hazard_rs1 || hazard_rs2);

  for (genvar r = 0; r < NR_REG; r++) begin : g_reg
    if (r == 0) begin : g_x0
      assign cnt[r]       = '0;
      assign at_max[r]    = 1'b0;
      assign err_r[r]     = 1'b0;
      assign busy_mask[r] = 1'b0;
    end else begin : g_xn
      ysyx_23060236_sb_counter #(.W(CNT_W)) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .inc    (fire && issue_reg_wen && (issue_rd == RW'(r))),
        .dec    (wdec && (wb_rd == RW'(r))),
        .cnt    (cnt[r]),
        .at_max (at_max[r]),
        .err    (err_r[r])
      );
      assign busy_mask[r] = (cnt[r] != '0);
    end
  end

  ysyx_23060236_sb_counter #(.W(OUT_W)) u_outstanding (
    .clock  (clock),
    .reset  (reset),
    .inc    (fire),
    .dec    (retire_valid),
    .cnt    (out_cnt),
    .at_max (out_max),
    .err    (out_err)
  );

  assign drained = (out_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sb_err_q <= 1'b0;
    else if ((|err_r) || out_err) sb_err_q <= 1'b1;
  end
  assign sb_err = sb_err_q;

  // The serial instruction stays alone in flight until its own retire empties the pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SB_IDLE;
    end else begin
      case (state_q)
        SB_IDLE: begin
          if (fire && issue_serial)
            state_q <= SB_SERIAL;
          else if (issue_valid && issue_serial && !drained && !flush)
            state_q <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (flush)
            state_q <= SB_IDLE;
          else if (fire && issue_serial)
            state_q <= SB_SERIAL;
        end
        SB_SERIAL: begin
          if (retire_valid && (out_cnt == OUT_W'(1)))
            state_q <= SB_IDLE;
        end
        default: state_q <= SB_IDLE;
      endcase
    end
  end
endmodule
